adder_feedback_decoder: RTL and testbench

Recovers the per-sample increments from the running-sum stream produced by the adder-with-feedback accumulator, so that out[k] = in[k] − in[k−1] (mod 2^WIDTH). It is the inverse, or differentiator, end of the accumulator datapath. It sits downstream of the accumulator output, or of a link carrying it, and returns the original increment stream. Both sides use a valid/ready handshake with a one-deep registered output stage.

---
 rtl/adder_feedback_decoder.sv | 93 +++++++++
 tb/tb_adder_feedback_decoder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/adder_feedback_decoder.sv
// adder_feedback_decoder: differentiator that undoes an adder-with-feedback
// accumulator. It turns a running-sum stream back into increments:
// out[k] = in[k] - in[k-1] (mod 2^WIDTH). Valid/ready is used on both sides,
// and the output stage is one register deep.
//
// state | meaning
// ------+-----------------------------------------------------------------
// SYNC  | no valid previous sum; the next accepted sum is taken as absolute
// RUN   | prev holds the last accepted sum and is subtracted from the next
module adder_feedback_decoder #(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     in,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 resync,
    output logic [WIDTH-1:0]     out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 wrap_flag,
    output logic [CNT_WIDTH-1:0] sample_count
);

    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             accept;

    // A full output stage can be drained and refilled in the same cycle.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= SYNC;
        end else begin
            state <= state_next;
        end
    end

    // Next state. An accept always leaves the FSM in RUN, including an accept
    // that arrives together with resync. resync on its own re-arms SYNC.
    always_comb begin
        state_next = state;
        if (accept) begin
            state_next = RUN;
        end else if (resync) begin
            state_next = SYNC;
        end
    end

    // Subtraction base and difference, computed from the current state.
    always_comb begin
        base   = '0;
        if (state == RUN && !resync) begin
            base = prev;
        end
        diff   = in - base;
        borrow = (in < base);
    end

    // Output register, previous-sum register and the accepted-sample counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out          <= '0;
            out_valid    <= 1'b0;
            wrap_flag    <= 1'b0;
            prev         <= '0;
            sample_count <= '0;
        end else if (accept) begin
            out          <= diff;
            wrap_flag    <= borrow;
            out_valid    <= 1'b1;
            prev         <= in;
            sample_count <= sample_count + 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adder_feedback_decoder.sv
// Directed testbench for adder_feedback_decoder. Inputs change 1 ns after a
// rising edge, and outputs are checked before the next edge.
module tb_adder_feedback_decoder;

    logic        clk;
    logic        reset;
    logic [15:0] in;
    logic        in_valid;
    logic        in_ready;
    logic        resync;
    logic [15:0] out;
    logic        out_valid;
    logic        out_ready;
    logic        wrap_flag;
    logic [7:0]  sample_count;

    int n_cmp;
    int n_err;

    adder_feedback_decoder #(.WIDTH(16), .CNT_WIDTH(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .in           (in),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .resync       (resync),
        .out          (out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .wrap_flag    (wrap_flag),
        .sample_count (sample_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one sum for exactly one edge and then return the input to idle.
    task automatic send(input logic [15:0] sum, input logic rs);
        in       = sum;
        in_valid = 1'b1;
        resync   = rs;
        tick();
        in_valid = 1'b0;
        resync   = 1'b0;
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        reset     = 1'b0;
        in        = '0;
        in_valid  = 1'b0;
        resync    = 1'b0;
        out_ready = 1'b1;

        #2;
        chk("rst_out",       out,          0);
        chk("rst_out_valid", out_valid,    0);
        chk("rst_wrap",      wrap_flag,    0);
        chk("rst_count",     sample_count, 0);
        chk("rst_in_ready",  in_ready,     1);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Basic inverse
        send(16'd5, 1'b0);
        chk("basic_out0", out, 5);
        chk("basic_val0", out_valid, 1);
        chk("basic_wrap0", wrap_flag, 0);
        send(16'd10, 1'b0);
        chk("basic_out1", out, 5);
        send(16'd210, 1'b0);
        chk("basic_out2", out, 200);
        chk("basic_wrap2", wrap_flag, 0);
        chk("basic_count", sample_count, 3);
        tick();
        chk("drain_valid", out_valid, 0);
        chk("drain_out_hold", out, 200);

        // Wrap-around
        send(16'd65530, 1'b1);
        chk("wrap_out0", out, 65530);
        chk("wrap_flag0", wrap_flag, 0);
        send(16'd4, 1'b0);
        chk("wrap_out1", out, 10);
        chk("wrap_flag1", wrap_flag, 1);
        send(16'd100, 1'b0);
        chk("wrap_out2", out, 96);
        chk("wrap_flag2", wrap_flag, 0);
        send(16'd40, 1'b0);
        chk("wrap_out3", out, 65476);
        chk("wrap_flag3", wrap_flag, 1);
        chk("wrap_count", sample_count, 7);

        // Backpressure
        send(16'd5, 1'b1);
        chk("bp_out0", out, 5);
        out_ready = 1'b0;
        in        = 16'd10;
        in_valid  = 1'b1;
        #1;
        chk("bp_in_ready_low", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_out", out, 5);
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_ready", in_ready, 0);
        end
        chk("bp_hold_count", sample_count, 8);
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_high", in_ready, 1);
        tick();
        chk("bp_out1", out, 5);
        in = 16'd15;
        tick();
        chk("bp_out2", out, 5);
        in_valid = 1'b0;
        tick();
        chk("bp_drained", out_valid, 0);
        chk("bp_count", sample_count, 10);

        // Resync on its own, then resync together with an accept
        send(16'd5, 1'b1);
        chk("rs_out0", out, 5);
        send(16'd10, 1'b0);
        chk("rs_out1", out, 5);
        resync = 1'b1;
        tick();
        resync = 1'b0;
        chk("rs_idle_valid", out_valid, 0);
        send(16'd300, 1'b0);
        chk("rs_out2", out, 300);
        send(16'd300, 1'b1);
        chk("rs_same_cycle", out, 300);
        chk("rs_same_wrap", wrap_flag, 0);
        chk("rs_count", sample_count, 14);

        // Async reset mid-operation, asserted between edges
        send(16'd5, 1'b1);
        out_ready = 1'b0;
        chk("ar_pre_out", out, 5);
        chk("ar_pre_valid", out_valid, 1);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_out", out, 0);
        chk("ar_valid", out_valid, 0);
        chk("ar_count", sample_count, 0);
        chk("ar_in_ready", in_ready, 1);
        @(negedge clk);
        reset     = 1'b1;
        out_ready = 1'b1;
        send(16'd42, 1'b0);
        chk("ar_first_out", out, 42);
        chk("ar_first_count", sample_count, 1);

        // Counter wrap: 256 back-to-back sums with a step of 1, starting from reset
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            in = 16'(1000 + i);
            tick();
            chk("cw_out", out, (i == 0) ? 32'd1000 : 32'd1);
            chk("cw_count", sample_count, 32'((i + 1) % 256));
        end
        in_valid = 1'b0;
        chk("cw_final_count", sample_count, 0);
        chk("cw_final_wrap", wrap_flag, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
